adder_arbiter: RTL and testbench
================================

Name: adder_arbiter

Overview:
- Shares one `sixty_four_bit_adder` instance among NUM_REQ requesters, for example the PC-increment, branch-target and address-generation paths.
- Grants round-robin, registers the adder operands, and returns a registered sum with the requester ID over a valid/ready response channel.
- Sits between the requesting datapath units and the shared adder.

Parameters:
- NUM_REQ, 4, number of requesters; legal range 2..8.
- ID_W, 2, width of resp_id; must equal ceil(log2(NUM_REQ)).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous active-high reset.
- req_valid  input  NUM_REQ  per-requester request strobe.
- req_a  input  64*NUM_REQ  operand A; requester i occupies bits [64*i+63:64*i].
- req_b  input  64*NUM_REQ  operand B; same packing as req_a.
- req_ready  output  NUM_REQ  one-hot accept pulse; operands sampled this cycle.
- resp_valid  output  1  result available.
- resp_ready  input  1  consumer accepts result.
- resp_id  output  ID_W  index of the requester that owns the result.
- resp_sum  output  64  registered sum from the adder.
- resp_cout  output  1  registered adder cout.
- resp_ovf  output  1  registered adder ovrflow.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (rst=1 at clock edge):
  - state=IDLE, rr_ptr=0.
  - req_ready=0, resp_valid=0, resp_id=0, resp_sum=0, resp_cout=0, resp_ovf=0, busy=0.
  - Reset mid-operation discards any in-flight request and its result; the dropped requester must re-request.
- FSM has three states: IDLE, CALC, RESP.
- IDLE:
  - If any req_valid bit is set, grant the first set bit found scanning from rr_ptr upward, wrapping modulo NUM_REQ.
  - req_ready[grant] is driven combinationally high in that same cycle.
  - At the clock edge: latch req_a/req_b of the grant into op_a/op_b, latch the grant into id_q, set rr_ptr = (grant+1) mod NUM_REQ, and go to CALC.
  - If no req_valid bit is set, stay in IDLE; req_ready=0.
- CALC:
  - The adder is driven from op_a/op_b only, never directly from request inputs.
  - At the clock edge, capture sum/cout/ovrflow into resp_sum/resp_cout/resp_ovf, set resp_id=id_q, and go to RESP.
- RESP:
  - resp_valid=1.
  - resp_id, resp_sum, resp_cout and resp_ovf are held stable until the handshake.
  - On resp_valid & resp_ready at the edge, go to IDLE.
  - No new grant is made in RESP, so the block has one outstanding transaction only.
- Latency: grant in cycle N, resp_valid high from cycle N+2. With resp_ready tied high, one transaction completes every 3 cycles.
- req_ready is zero in CALC and RESP regardless of req_valid.
- Requesters must hold req_valid and operands stable until they see their req_ready.
- A requester deasserting req_valid before being granted is legal; it is simply not granted.
- Simultaneous requests: exactly one grant per IDLE cycle. No requester waits more than NUM_REQ grants.
- Arithmetic: resp_sum = (op_a + op_b) mod 2^64.
  - resp_cout = carry out of bit 63.
  - resp_ovf = signed two's-complement overflow.
- rr_ptr wraps from NUM_REQ-1 to 0.

Optional Feature:
- Macro ADDER_ARB_SUB_EN.
- When defined:
  - Adds input req_sub [NUM_REQ-1:0]; latched with the operands at grant.
  - If the latched sub bit is set, a NEG state is inserted before CALC.
  - NEG drives the adder with a=~op_b, b=64'h1, writes the sum back into op_b, then goes to CALC.
  - resp_sum = op_a - op_b (mod 2^64). Subtract latency is N+3.
  - resp_cout and resp_ovf are the flags of the CALC pass only; the flags from the NEG pass are discarded.
  - Add requests (sub bit = 0) keep the N+2 latency.
- When undefined: no req_sub port, no NEG state, and behaviour is exactly as above.

Test Plan:
- Reset, then single request: rst held 2 cycles → all outputs 0. Requester 0 sends a=2, b=3 → req_ready=4'b0001 same cycle; resp_valid two cycles later with resp_id=0, resp_sum=5, cout=0, ovf=0.
- All four requesters valid together, resp_ready=1:
  - Operands are a=i+1, b=10*(i+1) for requester i.
  - Grants come in order 0,1,2,3, each 3 cycles apart.
  - Sums are 11, 22, 33, 44.
  - rr_ptr returns to 0.
- Backpressure: resp_ready=0 for 5 cycles during RESP with a=7, b=8 → resp_valid stays 1 with resp_sum=15 held stable; req_ready stays 0 while requester 1 is pending; requester 1 is granted in the first IDLE cycle after the handshake.
- Flags:
  - a=64'hFFFFFFFFFFFFFFFF, b=1 → sum 0, cout=1, ovf=0.
  - a=64'h7FFFFFFFFFFFFFFF, b=1 → sum 64'h8000000000000000, cout=0, ovf=1.
- Reset mid-CALC: rst asserted in the CALC cycle → next cycle state=IDLE, resp_valid=0; resp_valid never rises for the dropped request.
- ADDER_ARB_SUB_EN: a=10, b=3, sub=1 → resp_sum=7, latency N+3. An add request that follows still has latency N+2.

Source files
------------

// File: rtl/adder_arbiter_if.sv
// Request/response bundle between datapath requesters and adder_arbiter.
// req_sub is present only when ADDER_ARB_SUB_EN is defined.
interface adder_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
);
    logic [NUM_REQ-1:0]    req_valid;
    logic [64*NUM_REQ-1:0] req_a;
    logic [64*NUM_REQ-1:0] req_b;
`ifdef ADDER_ARB_SUB_EN
    logic [NUM_REQ-1:0]    req_sub;
`endif
    logic [NUM_REQ-1:0]    req_ready;
    logic                  resp_valid;
    logic                  resp_ready;
    logic [ID_W-1:0]       resp_id;
    logic [63:0]           resp_sum;
    logic                  resp_cout;
    logic                  resp_ovf;

    modport master (
`ifdef ADDER_ARB_SUB_EN
        output req_sub,
`endif
        output req_valid, req_a, req_b, resp_ready,
        input  req_ready, resp_valid, resp_id, resp_sum, resp_cout, resp_ovf
    );

    modport slave (
`ifdef ADDER_ARB_SUB_EN
        input  req_sub,
`endif
        input  req_valid, req_a, req_b, resp_ready,
        output req_ready, resp_valid, resp_id, resp_sum, resp_cout, resp_ovf
    );
endinterface

// File: rtl/adder_arbiter.sv
// Round-robin arbiter sharing one 64-bit adder among NUM_REQ requesters.
// Define ADDER_ARB_SUB_EN to add per-request subtraction through a NEG pass.
module sixty_four_bit_adder (
    input  logic [63:0] a_i,
    input  logic [63:0] b_i,
    output logic [63:0] sum_o,
    output logic        cout_o,
    output logic        ovrflow_o
);
    logic signed [63:0] a_s;
    logic signed [63:0] b_s;
    logic signed [63:0] sum_s;

    assign {cout_o, sum_o} = {1'b0, a_i} + {1'b0, b_i};
    assign a_s   = a_i;
    assign b_s   = b_i;
    assign sum_s = sum_o;
    // Overflow: operands share a sign that the result does not.
    assign ovrflow_o = ((a_s < 64'sd0) == (b_s < 64'sd0)) && ((sum_s < 64'sd0) != (a_s < 64'sd0));
endmodule

module adder_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic           clk,
    input  logic           rst,
    adder_arbiter_if.slave bus,
    output logic           busy
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        RESP = 2'd2
`ifdef ADDER_ARB_SUB_EN
        , NEG = 2'd3
`endif
    } state_t;

    state_t          state_q, state_d;
    logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0] id_q, id_d;
    logic [ID_W-1:0] resp_id_q, resp_id_d;
    logic [63:0]     op_a_q, op_a_d;
    logic [63:0]     op_b_q, op_b_d;
    logic [63:0]     resp_sum_q, resp_sum_d;
    logic            resp_cout_q, resp_cout_d;
    logic            resp_ovf_q, resp_ovf_d;
`ifdef ADDER_ARB_SUB_EN
    logic            sub_q, sub_d;
`endif

    logic            gnt_vld;
    logic [ID_W-1:0] gnt_idx;
    logic [63:0]     req_a_arr [NUM_REQ];
    logic [63:0]     req_b_arr [NUM_REQ];
    logic [63:0]     add_a, add_b, add_sum;
    logic            add_cout, add_ovf;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign req_a_arr[g] = bus.req_a[64*g +: 64];
        assign req_b_arr[g] = bus.req_b[64*g +: 64];
    end

    // First valid requester at or after rr_ptr_q, wrapping modulo NUM_REQ.
    always_comb begin
        int              j;
        logic [ID_W-1:0] j_idx;
        j       = 0;
        j_idx   = '0;
        gnt_vld = 1'b0;
        gnt_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            j = int'(rr_ptr_q) + k;
            if (j >= NUM_REQ) j = j - NUM_REQ;
            j_idx = ID_W'(j);
            if (!gnt_vld && bus.req_valid[j_idx]) begin
                gnt_vld = 1'b1;
                gnt_idx = j_idx;
            end
        end
    end

    always_comb begin
        add_a = op_a_q;
        add_b = op_b_q;
`ifdef ADDER_ARB_SUB_EN
        if (state_q == NEG) begin
            add_a = ~op_b_q;
            add_b = 64'h1;
        end
`endif
    end

    sixty_four_bit_adder u_adder (
        .a_i       (add_a),
        .b_i       (add_b),
        .sum_o     (add_sum),
        .cout_o    (add_cout),
        .ovrflow_o (add_ovf)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            resp_id_q   <= '0;
            resp_sum_q  <= '0;
            resp_cout_q <= 1'b0;
            resp_ovf_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            resp_id_q   <= resp_id_d;
            resp_sum_q  <= resp_sum_d;
            resp_cout_q <= resp_cout_d;
            resp_ovf_q  <= resp_ovf_d;
        end
        op_a_q <= op_a_d;
        op_b_q <= op_b_d;
        id_q   <= id_d;
`ifdef ADDER_ARB_SUB_EN
        sub_q  <= sub_d;
`endif
    end

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        id_d        = id_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        resp_id_d   = resp_id_q;
        resp_sum_d  = resp_sum_q;
        resp_cout_d = resp_cout_q;
        resp_ovf_d  = resp_ovf_q;
`ifdef ADDER_ARB_SUB_EN
        sub_d       = sub_q;
`endif
        case (state_q)
            IDLE: begin
                if (gnt_vld) begin
                    op_a_d   = req_a_arr[gnt_idx];
                    op_b_d   = req_b_arr[gnt_idx];
                    id_d     = gnt_idx;
                    rr_ptr_d = (int'(gnt_idx) == NUM_REQ - 1) ? '0 : gnt_idx + ID_W'(1);
                    state_d  = CALC;
`ifdef ADDER_ARB_SUB_EN
                    sub_d    = bus.req_sub[gnt_idx];
                    if (bus.req_sub[gnt_idx]) state_d = NEG;
`endif
                end
            end
`ifdef ADDER_ARB_SUB_EN
            // Two's-complement negate of op_b, then a normal add pass.
            NEG: begin
                op_b_d  = add_sum;
                state_d = CALC;
            end
`endif
            CALC: begin
                resp_sum_d  = add_sum;
                resp_cout_d = add_cout;
                resp_ovf_d  = add_ovf;
                resp_id_d   = id_q;
                state_d     = RESP;
            end
            RESP: begin
                if (bus.resp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready = '0;
        if (state_q == IDLE && gnt_vld) bus.req_ready[gnt_idx] = 1'b1;
        bus.resp_valid = (state_q == RESP);
        bus.resp_id    = resp_id_q;
        bus.resp_sum   = resp_sum_q;
        bus.resp_cout  = resp_cout_q;
        bus.resp_ovf   = resp_ovf_q;
        busy           = (state_q != IDLE);
    end
endmodule

// File: tb/tb_adder_arbiter.sv
// Directed and randomized bench for adder_arbiter against a round-robin/arithmetic reference model.
module tb_adder_arbiter;
  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;

  logic clk = 1'b0;
  logic rst;
  logic busy;
  int   vectors     = 0;
  int   miscompares = 0;
  int   ptr         = 0;

  logic [63:0]        a_in [NUM_REQ];
  logic [63:0]        b_in [NUM_REQ];
  logic [NUM_REQ-1:0] vmask;
  logic [NUM_REQ-1:0] sub_mask;

  adder_arbiter_if #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) bus ();

  adder_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .busy (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply();
    bus.req_valid = vmask;
    for (int i = 0; i < NUM_REQ; i++) begin
      bus.req_a[64*i +: 64] = a_in[i];
      bus.req_b[64*i +: 64] = b_in[i];
    end
`ifdef ADDER_ARB_SUB_EN
    bus.req_sub = sub_mask;
`endif
  endtask

  function automatic int rr_pick(input int p, input logic [NUM_REQ-1:0] m);
    for (int k = 0; k < NUM_REQ; k++)
      if (m[(p + k) % NUM_REQ]) return (p + k) % NUM_REQ;
    return 0;
  endfunction

  function automatic void model(input logic [63:0] a, input logic [63:0] b,
                                output logic [63:0] s, output logic c, output logic o);
    longint signed sa, sb, ss;
    s  = a + b;
    c  = (s < a);
    sa = a;
    sb = b;
    ss = s;
    o  = ((sa < 0) == (sb < 0)) && ((ss < 0) != (sa < 0));
  endfunction

  task automatic check_quiet(input string tag);
    chk({tag, "_ready"}, 64'(bus.req_ready), 64'(0));
    chk({tag, "_rvalid"}, 64'(bus.resp_valid), 64'(0));
    chk({tag, "_busy"}, 64'(busy), 64'(1));
  endtask

  task automatic reset_dut();
    rst   = 1'b1;
    vmask = '0;
    apply();
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("rst_ready", 64'(bus.req_ready), 64'(0));
    chk("rst_rvalid", 64'(bus.resp_valid), 64'(0));
    chk("rst_id", 64'(bus.resp_id), 64'(0));
    chk("rst_sum", bus.resp_sum, 64'(0));
    chk("rst_cout", 64'(bus.resp_cout), 64'(0));
    chk("rst_ovf", 64'(bus.resp_ovf), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    ptr = 0;
  endtask

  // Called at posedge+1 of an IDLE cycle; returns at posedge+1 of the next IDLE cycle.
  task automatic transact(input int hold);
    int          g;
    logic        is_sub;
    logic [63:0] es, bop;
    logic        ec, eo;
    apply();
    #1;
    g      = rr_pick(ptr, vmask);
    is_sub = sub_mask[g];
    bop    = is_sub ? (64'(0) - b_in[g]) : b_in[g];
    model(a_in[g], bop, es, ec, eo);
    chk("grant_ready", 64'(bus.req_ready), 64'(1) << g);
    chk("grant_busy", 64'(busy), 64'(0));
    ptr = (g + 1) % NUM_REQ;
    tick();
    vmask[g] = 1'b0;
    apply();
    #1;
    if (is_sub) begin
      check_quiet("neg");
      tick();
      #1;
    end
    check_quiet("calc");
    tick();
    #1;
    chk("resp_valid", 64'(bus.resp_valid), 64'(1));
    chk("resp_id", 64'(bus.resp_id), 64'(g));
    chk("resp_sum", bus.resp_sum, es);
    chk("resp_cout", 64'(bus.resp_cout), 64'(ec));
    chk("resp_ovf", 64'(bus.resp_ovf), 64'(eo));
    bus.resp_ready = (hold == 0);
    for (int h = 0; h < hold; h++) begin
      tick();
      #1;
      chk("hold_valid", 64'(bus.resp_valid), 64'(1));
      chk("hold_sum", bus.resp_sum, es);
      chk("hold_ready", 64'(bus.req_ready), 64'(0));
      if (h == hold - 1) bus.resp_ready = 1'b1;
    end
    tick();
  endtask

  initial begin
    int g;
    rst            = 1'b1;
    bus.resp_ready = 1'b1;
    vmask          = '0;
    sub_mask       = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      a_in[i] = '0;
      b_in[i] = '0;
    end
    apply();
    reset_dut();

    // Single request from requester 0.
    a_in[0] = 64'd2;
    b_in[0] = 64'd3;
    vmask   = 4'b0001;
    transact(0);

    // All four together from a fresh pointer.
    reset_dut();
    for (int i = 0; i < NUM_REQ; i++) begin
      a_in[i] = 64'(i + 1);
      b_in[i] = 64'(10 * (i + 1));
    end
    vmask = 4'b1111;
    for (int i = 0; i < NUM_REQ; i++) transact(0);

    // Backpressure with requester 1 pending.
    a_in[0] = 64'd7;
    b_in[0] = 64'd8;
    a_in[1] = 64'd100;
    b_in[1] = 64'd23;
    vmask   = 4'b0011;
    transact(5);
    transact(0);

    // Flag corners.
    a_in[2] = 64'hFFFF_FFFF_FFFF_FFFF;
    b_in[2] = 64'd1;
    vmask   = 4'b0100;
    transact(0);
    a_in[3] = 64'h7FFF_FFFF_FFFF_FFFF;
    b_in[3] = 64'd1;
    vmask   = 4'b1000;
    transact(0);

    // Randomized traffic.
    for (int n = 0; n < 40; n++) begin
      vmask = NUM_REQ'($urandom_range(1, (1 << NUM_REQ) - 1));
      for (int i = 0; i < NUM_REQ; i++) begin
        a_in[i] = {$urandom, $urandom};
        b_in[i] = ($urandom_range(0, 3) == 0) ? ~a_in[i] + 64'(n % 2) : {$urandom, $urandom};
      end
      transact(int'($urandom_range(0, 3)));
    end

`ifdef ADDER_ARB_SUB_EN
    a_in[3]  = 64'd10;
    b_in[3]  = 64'd3;
    vmask    = 4'b1000;
    sub_mask = 4'b1000;
    transact(0);
    for (int n = 0; n < 8; n++) begin
      vmask    = NUM_REQ'($urandom_range(1, (1 << NUM_REQ) - 1));
      sub_mask = NUM_REQ'($urandom);
      for (int i = 0; i < NUM_REQ; i++) begin
        a_in[i] = {$urandom, $urandom};
        b_in[i] = {$urandom, $urandom};
      end
      transact(int'($urandom_range(0, 2)));
    end
    sub_mask = '0;
    a_in[3]  = 64'd5;
    b_in[3]  = 64'd6;
    vmask    = 4'b1000;
    transact(0);
`endif

    // Reset during CALC drops the transaction.
    a_in[2] = 64'd40;
    b_in[2] = 64'd2;
    vmask   = 4'b0100;
    apply();
    #1;
    g = rr_pick(ptr, vmask);
    chk("midrst_grant", 64'(bus.req_ready), 64'(1) << g);
    tick();
    vmask = '0;
    apply();
    rst = 1'b1;
    #1;
    chk("midrst_busy", 64'(busy), 64'(1));
    tick();
    rst = 1'b0;
    ptr = 0;
    #1;
    chk("midrst_rvalid", 64'(bus.resp_valid), 64'(0));
    chk("midrst_idle", 64'(busy), 64'(0));
    chk("midrst_sum", bus.resp_sum, 64'(0));
    for (int n = 0; n < 4; n++) begin
      tick();
      #1;
      chk("midrst_norise", 64'(bus.resp_valid), 64'(0));
    end

    // Pointer restarts at 0 after reset.
    a_in[1] = 64'd9;
    b_in[1] = 64'd9;
    a_in[3] = 64'd1;
    b_in[3] = 64'd1;
    vmask   = 4'b1010;
    transact(0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
